// File: rtl/fft_spectrum_buffer.sv
// Streaming FFT magnitude normaliser feeding a vsync-swapped ping-pong spectrum RAM.
// Optional SPEC_LOG_EN adds a log2-compression stage (write latency 4 -> 5).
module fft_spectrum_buffer #(
    parameter int IN_W    = 12,
    parameter int DATA_W  = 10,
    parameter int FFT_LEN = 1024,
    parameter int ADDR_W  = 10,
    parameter int EXP_REF = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              source_sop,
    input  logic              source_valid,
    input  logic [5:0]        source_exp,
    input  logic [IN_W-1:0]   source_real,
    input  logic [IN_W-1:0]   source_imag,
    input  logic              disp_vsync,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic              frame_err
);
    localparam int MAG_W  = IN_W + 1;
    localparam int WIDE_W = MAG_W + DATA_W;
    localparam logic [DATA_W-1:0] SAT  = '1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_LEN - 1);

    typedef enum logic {IDLE, FILL} wr_state_t;

    logic [5:0]        exp_f, exp_in, e1, e2, e3;
    logic              v1, v2, v3, v4, s1, s2, s3, s4;
    logic [IN_W-1:0]   abs_re, abs_im, mx, mn;
    logic [MAG_W-1:0]  mag;
    logic signed [7:0] sh;
    logic [WIDE_W-1:0] wide;
    logic [DATA_W-1:0] lin, lin4;
    logic              p_val, p_sop;
    logic [DATA_W-1:0] p_data;

    // Exponent is latched on the sop beat and carried along with every beat of the frame
    assign exp_in = (source_valid && source_sop) ? source_exp : exp_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_f <= '0;
            {v1, v2, v3, v4} <= '0;
            {s1, s2, s3, s4} <= '0;
        end else begin
            exp_f <= exp_in;
            v1 <= source_valid;
            s1 <= source_valid && source_sop;
            {v2, v3, v4} <= {v1, v2, v3};
            {s2, s3, s4} <= {s1, s2, s3};
        end
    end

    always_ff @(posedge clk) begin
        abs_re <= source_real[IN_W-1] ? -source_real : source_real;
        abs_im <= source_imag[IN_W-1] ? -source_imag : source_imag;
        e1     <= exp_in;
        mx     <= (abs_re > abs_im) ? abs_re : abs_im;
        mn     <= (abs_re > abs_im) ? abs_im : abs_re;
        e2     <= e1;
        mag    <= MAG_W'(mx) + MAG_W'(mn >> 2) + MAG_W'(mn >> 3);
        e3     <= e2;
        lin4   <= lin;
    end

    always_comb begin
        sh   = -8'(signed'(e3)) - 8'(EXP_REF);
        wide = '0;
        if (!sh[7]) begin
            if (sh > 8'(DATA_W)) wide = (mag != '0) ? '1 : '0;
            else                 wide = WIDE_W'(mag) << sh;
        end else begin
            wide = WIDE_W'(mag) >> (-sh);
        end
        lin = (wide > WIDE_W'(SAT)) ? SAT : wide[DATA_W-1:0];
    end

`ifdef SPEC_LOG_EN
    logic [3:0]        lead;
    logic [2:0]        frac;
    logic [DATA_W-1:0] logv, log5;
    logic              v5, s5;

    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
            if (lin4[i]) lead = 4'(i);
        frac = 3'({lin4, 3'b000} >> lead);
        logv = (lin4 == '0) ? '0 : DATA_W'({lead, frac});
    end

    always_ff @(posedge clk) begin
        if (rst) {v5, s5} <= '0;
        else     {v5, s5} <= {v4, s4};
        log5 <= logv;
    end

    assign p_val  = v5;
    assign p_sop  = s5;
    assign p_data = log5;
`else
    assign p_val  = v4;
    assign p_sop  = s4;
    assign p_data = lin4;
`endif

    wr_state_t         state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx, wr_bin;
    logic              wr_en, done, err, pending, disp_bank, swap;
    logic [DATA_W-1:0] mem [2*FFT_LEN];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (p_val) begin
            if (p_sop)                             state_nx = FILL;
            else if (state == FILL && cnt == LAST) state_nx = IDLE;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_bin = cnt;
        cnt_nx = cnt;
        done   = 1'b0;
        err    = 1'b0;
        if (p_val) begin
            if (p_sop) begin
                wr_en  = 1'b1;
                wr_bin = '0;
                cnt_nx = ADDR_W'(1);
                err    = (state == FILL);
            end else if (state == FILL) begin
                wr_en  = 1'b1;
                cnt_nx = cnt + ADDR_W'(1);
                done   = (cnt == LAST);
            end
        end
    end

    // IDLE at the write stage means every in-flight beat of the finished frame has landed
    assign swap = disp_vsync && pending && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pending   <= 1'b0;
            disp_bank <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            frame_err <= err;
            if (done)      pending <= 1'b1;
            else if (swap) pending <= 1'b0;
            if (swap) disp_bank <= ~disp_bank;
        end
    end

    assign frame_ready = pending;

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[{~disp_bank, wr_bin}] <= p_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[{disp_bank, rd_addr}];
        else            rd_data <= '0;
    end
endmodule
